code_lock_fsm: RTL

Parametrised sequential code-lock checker: compares a stream of entered digits against a stored multi-digit code one digit per strobe and reports per-digit verdicts. It adds restart-on-first-digit, a retry budget with timed lockout, an explicit unlock state and an optional per-attempt digit sum. It sits between the keypad/input front end and the unlock actuator logic.

---
 rtl/code_lock_fsm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/code_lock_fsm.sv
// -----------------------------------------------------------------------------
// code_lock_fsm
//
// Sequential code-lock checker. A stored multi-digit code is compared against
// a stream of entered digits, one digit per digit_valid strobe. Each digit gets
// a verdict pulse (ok / bad / restart). A retry budget leads to a timed lockout.
// A successful full-code match enters an explicit OPEN state. An optional
// per-attempt digit sum can also be built.
//
// Optional feature macro: CODE_LOCK_SUM_EN
//   defined   : digit_sum accumulates the digits of the current attempt
//   undefined : no accumulator is built, digit_sum is constant 0
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   code_load    in   capture code_in and start a new session (IDLE/OPEN only)
//   code_in      in   code; digit k = [k*DIGIT_W +: DIGIT_W], digit 0 entered first
//   clear        in   abandon current attempt (ENTRY) / relock (OPEN)
//   digit_valid  in   digit_in is presented this cycle
//   digit_in     in   entered digit
//   digit_ok     out  pulse: correct digit
//   digit_bad    out  pulse: wrong digit, one try consumed
//   restart      out  pulse: wrong digit equal to code digit 0, entry restarted
//   unlocked     out  level: in OPEN
//   locked_out   out  level: in LOCKOUT
//   progress     out  digits matched so far
//   tries_left   out  remaining tries
//   digit_sum    out  sum of digits in the current attempt (mod 2^SUM_W)
//   dbg_state    out  current FSM state (0 IDLE, 1 ENTRY, 2 OPEN, 3 LOCKOUT)
//
// Input handshake: digit_valid is a single-cycle strobe with no back-pressure;
// a digit is consumed on every clock edge that samples digit_valid=1 in ENTRY
// when neither code_load nor clear is asserted. Priority is
// code_load > clear > digit_valid; any asserted higher-priority input masks the
// lower ones even when the higher one itself is ignored in the current state.
// -----------------------------------------------------------------------------
module code_lock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int SUM_W          = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          code_load,
  input  logic [DIGITS*DIGIT_W-1:0]     code_in,
  input  logic                          clear,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit_in,
  output logic                          digit_ok,
  output logic                          digit_bad,
  output logic                          restart,
  output logic                          unlocked,
  output logic                          locked_out,
  output logic [$clog2(DIGITS+1)-1:0]   progress,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [SUM_W-1:0]              digit_sum,
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(DIGITS+1);
  localparam int TW = $clog2(MAX_TRIES+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t                    r_state;
  logic [DIGITS*DIGIT_W-1:0] r_code;
  logic [PW-1:0]             r_progress;
  logic [TW-1:0]             r_tries;
  logic [LW-1:0]             r_lock_cnt;
  logic                      r_digit_ok;
  logic                      r_digit_bad;
  logic                      r_restart;
  logic                      r_unlocked;
  logic                      r_locked_out;

  logic [DIGIT_W-1:0]        w_code_digit;
  logic                      w_load;
  logic                      w_clear;
  logic                      w_digit;
  logic                      w_match;
  logic                      w_first;
  logic                      w_ok;
  logic                      w_restart;
  logic                      w_bad;
  logic                      w_lock_exit;

  // Code digit selected by the current progress count.
  always_comb begin
    w_code_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_progress == PW'(k)) w_code_digit = r_code[k*DIGIT_W +: DIGIT_W];
    end
  end

  // Event decode shared by the FSM and the optional accumulator.
  always_comb begin
    w_load      = code_load && (r_state == IDLE || r_state == OPEN);
    w_clear     = !code_load && clear && (r_state == ENTRY || r_state == OPEN);
    w_digit     = !code_load && !clear && digit_valid && (r_state == ENTRY);
    w_match     = (digit_in == w_code_digit);
    w_first     = (digit_in == r_code[DIGIT_W-1:0]);
    w_ok        = w_digit && w_match;
    // A wrong digit that could begin the code restarts entry instead of
    // costing a try, but only once at least one digit has matched.
    w_restart   = w_digit && !w_match && (r_progress != '0) && w_first;
    w_bad       = w_digit && !w_match && !((r_progress != '0) && w_first);
    w_lock_exit = (r_state == LOCKOUT) && (r_lock_cnt == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_code       <= '0;
      r_progress   <= '0;
      r_tries      <= '0;
      r_lock_cnt   <= '0;
      r_digit_ok   <= 1'b0;
      r_digit_bad  <= 1'b0;
      r_restart    <= 1'b0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_digit_ok  <= 1'b0;
      r_digit_bad <= 1'b0;
      r_restart   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_code     <= code_in;
            r_state    <= ENTRY;
            r_progress <= '0;
            r_tries    <= TW'(MAX_TRIES);
          end
        end
        ENTRY: begin
          if (w_clear) begin
            r_progress <= '0;
          end else if (w_ok) begin
            r_digit_ok <= 1'b1;
            r_progress <= r_progress + PW'(1);
            if (r_progress == PW'(DIGITS-1)) begin
              r_state    <= OPEN;
              r_unlocked <= 1'b1;
            end
          end else if (w_restart) begin
            r_restart  <= 1'b1;
            r_progress <= PW'(1);
          end else if (w_bad) begin
            r_digit_bad <= 1'b1;
            r_progress  <= '0;
            r_tries     <= r_tries - TW'(1);
            if (r_tries == TW'(1)) begin
              r_state      <= LOCKOUT;
              r_locked_out <= 1'b1;
              // Edge that enters LOCKOUT counts as the first lockout cycle.
              r_lock_cnt   <= LW'(LOCKOUT_CYCLES-1);
            end
          end
        end
        OPEN: begin
          if (w_load) begin
            r_code     <= code_in;
            r_state    <= ENTRY;
            r_unlocked <= 1'b0;
            r_progress <= '0;
            r_tries    <= TW'(MAX_TRIES);
          end else if (w_clear) begin
            r_state    <= ENTRY;
            r_unlocked <= 1'b0;
            r_progress <= '0;
            r_tries    <= TW'(MAX_TRIES);
          end
        end
        LOCKOUT: begin
          if (w_lock_exit) begin
            r_state      <= ENTRY;
            r_locked_out <= 1'b0;
            r_tries      <= TW'(MAX_TRIES);
            r_progress   <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt - LW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CODE_LOCK_SUM_EN
  logic [SUM_W-1:0] r_digit_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_digit_sum <= '0;
    end else if (w_load || w_clear || w_bad || w_lock_exit) begin
      r_digit_sum <= '0;
    end else if (w_ok) begin
      r_digit_sum <= r_digit_sum + SUM_W'(digit_in);
    end else if (w_restart) begin
      r_digit_sum <= SUM_W'(digit_in);
    end
  end

  assign digit_sum = r_digit_sum;
`else
  assign digit_sum = '0;
`endif

  assign digit_ok   = r_digit_ok;
  assign digit_bad  = r_digit_bad;
  assign restart    = r_restart;
  assign unlocked   = r_unlocked;
  assign locked_out = r_locked_out;
  assign progress   = r_progress;
  assign tries_left = r_tries;
  assign dbg_state  = r_state;

endmodule
